// File: rtl/cep_encoder_ser_pkg.sv
// ============================================================================
// cep_encoder_ser_pkg : CEP package layout, field records and channel indices
// Revision: 1.0
// ============================================================================
`default_nettype none

package cep_encoder_ser_pkg;

    localparam int CEP_WORD_W          = 64;
    localparam int CEP_NUM_WORDS       = 8;
    localparam int CEP_DATA_WIDTH      = CEP_WORD_W * CEP_NUM_WORDS;

    localparam int CEP_MSG_TYPE_W      = 8;
    localparam int CEP_MSHRID_W        = 8;
    localparam int CEP_DATA_SIZE_W     = 3;
    localparam int CEP_ADDR_W          = 40;
    localparam int CEP_CHIPID_W        = 14;
    localparam int CEP_MESI_W          = 2;
    localparam int CEP_SUBLINE_W       = 2;
    localparam int CEP_INT_ID_WIDTH    = 16;
    localparam int CEP_REQ_DATA_WORDS  = 5;
    localparam int CEP_RESP_DATA_WORDS = 7;

    // Absolute bit positions inside the encoded package
    localparam int CEP_IS_REQ          = 0;
    localparam int CEP_IS_RESP         = 1;
    localparam int CEP_IS_INT          = 2;
    localparam int CEP_MSG_TYPE        = 3;
    localparam int CEP_MSHRID          = 11;
    localparam int CEP_DATA_SIZE       = 19;
    localparam int CEP_CACHE_TYPE      = 22;
    localparam int CEP_MESI            = 19;
    localparam int CEP_SUBLINE_ID      = 21;
    localparam int CEP_LAST_SUBLINE    = 23;
    localparam int CEP_INT_ID          = 24;
    localparam int CEP_ADDR            = 64;
    localparam int CEP_SRC_CHIPID      = 104;
    localparam int CEP_REQ_DATA_WORD0  = 3;
    localparam int CEP_RESP_DATA_WORD0 = 1;

    typedef struct packed {
        logic [CEP_MSG_TYPE_W-1:0]                         msg_type;
        logic [CEP_MSHRID_W-1:0]                           mshrid;
        logic [CEP_DATA_SIZE_W-1:0]                        data_size;
        logic                                              cache_type;
        logic [CEP_ADDR_W-1:0]                             addr;
        logic [CEP_CHIPID_W-1:0]                           src_chipid;
        logic [CEP_REQ_DATA_WORDS-1:0][CEP_WORD_W-1:0]     data;
    } cep_req_t;

    typedef struct packed {
        logic [CEP_MSG_TYPE_W-1:0]                         msg_type;
        logic [CEP_MSHRID_W-1:0]                           mshrid;
        logic [CEP_MESI_W-1:0]                             mesi;
        logic [CEP_SUBLINE_W-1:0]                          subline_id;
        logic                                              last_subline;
        logic [CEP_RESP_DATA_WORDS-1:0][CEP_WORD_W-1:0]    data;
    } cep_resp_t;

    localparam int CEP_REQ_FIELDS_W  = $bits(cep_req_t);
    localparam int CEP_RESP_FIELDS_W = $bits(cep_resp_t);
    localparam int CEP_MUX_W_RQ      = (CEP_REQ_FIELDS_W > CEP_RESP_FIELDS_W) ?
                                       CEP_REQ_FIELDS_W : CEP_RESP_FIELDS_W;
    localparam int CEP_MUX_W         = (CEP_MUX_W_RQ > CEP_INT_ID_WIDTH) ?
                                       CEP_MUX_W_RQ : CEP_INT_ID_WIDTH;

    typedef enum logic [1:0] {
        CH_RESP = 2'd0,
        CH_REQ  = 2'd1,
        CH_INT  = 2'd2
    } cep_ch_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Channel k steps after c in the cyclic order resp -> req -> int
    function automatic cep_ch_e ch_add(cep_ch_e c, int unsigned k);
        int unsigned s;
        s = (int'(c) + k) % 3;
        return cep_ch_e'(s[1:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cep_encoder_ser_encoder.sv
// ============================================================================
// cep_encoder : combinational packing of one channel's fields into a package
// Revision: 1.0
// ============================================================================
`default_nettype none

module cep_encoder
    import cep_encoder_ser_pkg::*;
(
    input  cep_ch_e                    ch,
    input  logic [CEP_MUX_W-1:0]       fields,
    output logic [CEP_DATA_WIDTH-1:0]  pkg_data
);

    cep_req_t                     req;
    cep_resp_t                    resp;
    logic [CEP_INT_ID_WIDTH-1:0]  iid;

    assign req  = cep_req_t'(fields[CEP_REQ_FIELDS_W-1:0]);
    assign resp = cep_resp_t'(fields[CEP_RESP_FIELDS_W-1:0]);
    assign iid  = fields[CEP_INT_ID_WIDTH-1:0];

    always_comb begin
        pkg_data = '0;
        case (ch)
            CH_REQ: begin
                pkg_data[CEP_IS_REQ]                             = 1'b1;
                pkg_data[CEP_MSG_TYPE   +: CEP_MSG_TYPE_W]       = req.msg_type;
                pkg_data[CEP_MSHRID     +: CEP_MSHRID_W]         = req.mshrid;
                pkg_data[CEP_DATA_SIZE  +: CEP_DATA_SIZE_W]      = req.data_size;
                pkg_data[CEP_CACHE_TYPE]                         = req.cache_type;
                pkg_data[CEP_ADDR       +: CEP_ADDR_W]           = req.addr;
                pkg_data[CEP_SRC_CHIPID +: CEP_CHIPID_W]         = req.src_chipid;
                for (int i = 0; i < CEP_REQ_DATA_WORDS; i++) begin
                    pkg_data[(CEP_REQ_DATA_WORD0 + i) * CEP_WORD_W +: CEP_WORD_W] = req.data[i];
                end
            end
            CH_RESP: begin
                pkg_data[CEP_IS_RESP]                            = 1'b1;
                pkg_data[CEP_MSG_TYPE   +: CEP_MSG_TYPE_W]       = resp.msg_type;
                pkg_data[CEP_MSHRID     +: CEP_MSHRID_W]         = resp.mshrid;
                pkg_data[CEP_MESI       +: CEP_MESI_W]           = resp.mesi;
                pkg_data[CEP_SUBLINE_ID +: CEP_SUBLINE_W]        = resp.subline_id;
                pkg_data[CEP_LAST_SUBLINE]                       = resp.last_subline;
                for (int i = 0; i < CEP_RESP_DATA_WORDS; i++) begin
                    pkg_data[(CEP_RESP_DATA_WORD0 + i) * CEP_WORD_W +: CEP_WORD_W] = resp.data[i];
                end
            end
            CH_INT: begin
                pkg_data[CEP_IS_INT]                             = 1'b1;
                pkg_data[CEP_INT_ID     +: CEP_INT_ID_WIDTH]     = iid;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cep_encoder_ser.sv
// ============================================================================
// cep_encoder_ser : arbitrates req/resp/int, encodes one CEP package and
// serialises it as FLIT_WIDTH flits. Define CEP_ENCODER_SER_RR_EN for RR grant.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cep_encoder_ser
    import cep_encoder_ser_pkg::*;
#(
    parameter int FLIT_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic [CEP_REQ_FIELDS_W-1:0]   req_fields,
    input  logic                          resp_val,
    output logic                          resp_rdy,
    input  logic [CEP_RESP_FIELDS_W-1:0]  resp_fields,
    input  logic                          int_val,
    output logic                          int_rdy,
    input  logic [CEP_INT_ID_WIDTH-1:0]   int_id,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [FLIT_WIDTH-1:0]         out_data,
    output logic                          out_last
);

    localparam int NUM_FLITS = (CEP_DATA_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH;
    localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int PKT_W     = NUM_FLITS * FLIT_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FLITS - 1);

    state_e                       state;
    state_e                       state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic [PKT_W-1:0]             pkt;
    logic [2:0]                   val_vec;
    cep_ch_e                      c0;
    cep_ch_e                      c1;
    cep_ch_e                      c2;
    logic                         grant_any;
    cep_ch_e                      grant_ch;
    logic                         accept;
    logic                         cnt_last;
    logic [CEP_MUX_W-1:0]         mux_fields;
    logic [CEP_DATA_WIDTH-1:0]    enc_pkg;

    assign val_vec = {int_val, req_val, resp_val};

`ifdef CEP_ENCODER_SER_RR_EN
    cep_ch_e ptr;

    assign c0 = ptr;
    assign c1 = ch_add(ptr, 1);
    assign c2 = ch_add(ptr, 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= CH_RESP;
        end else if (accept) begin
            ptr <= ch_add(grant_ch, 1);
        end
    end
`else
    assign c0 = CH_RESP;
    assign c1 = CH_REQ;
    assign c2 = CH_INT;
`endif

    // c0..c2 is the search order; first valid channel wins
    always_comb begin
        grant_any = 1'b1;
        grant_ch  = c0;
        if (val_vec[c0]) begin
            grant_ch = c0;
        end else if (val_vec[c1]) begin
            grant_ch = c1;
        end else if (val_vec[c2]) begin
            grant_ch = c2;
        end else begin
            grant_any = 1'b0;
        end
    end

    assign accept   = (state == S_IDLE) && grant_any;
    assign resp_rdy = accept && (grant_ch == CH_RESP);
    assign req_rdy  = accept && (grant_ch == CH_REQ);
    assign int_rdy  = accept && (grant_ch == CH_INT);

    always_comb begin
        mux_fields = '0;
        case (grant_ch)
            CH_REQ:  mux_fields = CEP_MUX_W'(req_fields);
            CH_RESP: mux_fields = CEP_MUX_W'(resp_fields);
            CH_INT:  mux_fields = CEP_MUX_W'(int_id);
            default: ;
        endcase
    end

    cep_encoder u_cep_encoder (
        .ch       (grant_ch),
        .fields   (mux_fields),
        .pkg_data (enc_pkg)
    );

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            pkt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pkt <= PKT_W'(enc_pkg);
                cnt <= '0;
            end else if (out_val && out_rdy && !cnt_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        out_val   = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                out_val  = 1'b1;
                out_last = cnt_last;
                out_data = pkt[cnt * FLIT_WIDTH +: FLIT_WIDTH];
                if (out_rdy && cnt_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
